fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32I core. It owns the architectural PC and fetches each instruction from instruction memory over a req/ack handshake.
- It presents the decode fields (opcode/funct3/funct7/register addresses) to the control decoder.
- On instruction retire it consumes the decoder's npc_op together with the branch flag, immediate and rs1 value, and computes the next PC.
- It replaces a purely combinational PC/NPC path so that multi-cycle instruction memories are supported.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word presented while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- npc_op  input  2  next-PC select from decoder; encoding per defines.v: NPC_PC4=2'b00, NPC_BRA=2'b01, NPC_JAL=2'b10, NPC_JALR=2'b11.
- br_taken  input  1  branch comparison result from ALU; used only when npc_op=NPC_BRA.
- imm  input  32  sign-extended immediate from sext.
- rs1_val  input  32  register rs1 value, used for JALR.
- retire  input  1  one-cycle pulse: the current instruction completes this cycle.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  fetch address (= pc).
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- pc  output  32  address of the held instruction.
- pc4  output  32  pc+4, for the WB_PC4 writeback.
- inst  output  32  held instruction word.
- inst_valid  output  1  inst is valid and executing.
- opcode  output  7  inst[6:0]
- funct3  output  3  inst[14:12]
- funct7  output  7  inst[31:25]
- rs1_addr  output  5  inst[19:15]
- rs2_addr  output  5  inst[24:20]
- rd_addr  output  5  inst[11:7]
- misalign  output  1  sticky: a computed next PC had bits [1:0] != 0.
- misalign_addr  output  32  the offending target address.
- retire_cnt  output  32  number of retired instructions; wraps.

Behaviour:
- Reset (rst=1 at an edge, overrides every other input, including mid-fetch):
  - pc=RESET_PC, inst=NOP_INST, inst_valid=0, imem_req=0.
  - misalign=0, misalign_addr=0, retire_cnt=0, state=IDLE.
- State machine:
  - IDLE -> FETCH unconditionally on the next edge; imem_req goes high entering FETCH.
  - FETCH:
    - imem_req=1; imem_addr=pc, held stable until ack.
    - On the edge where imem_ack=1: inst<=imem_rdata, inst_valid<=1, imem_req<=0, -> EXEC.
    - Minimum latency: request asserted in cycle N, ack in cycle N, inst_valid in cycle N+1.
  - EXEC:
    - inst_valid=1; inst and pc held stable until retire.
    - On retire, next-PC rule (all 32-bit, mod 2^32):
      - NPC_PC4: pc+4.
      - NPC_BRA: br_taken ? pc+imm : pc+4.
      - NPC_JAL: pc+imm.
      - NPC_JALR: (rs1_val+imm) & 32'hFFFF_FFFE.
    - If next[1:0]==0: pc<=next, inst<=NOP_INST, inst_valid<=0, retire_cnt<=retire_cnt+1, -> FETCH (imem_req=1 next cycle).
    - If next[1:0]!=0: retire_cnt increments, misalign<=1, misalign_addr<=next, pc unchanged, inst_valid<=0, imem_req stays 0, -> TRAP.
  - TRAP: terminal; all outputs hold; only rst exits.
- Fetch bubble: at least one cycle with inst_valid=0 between consecutive instructions.
- Ignored inputs:
  - retire outside EXEC: no state change, no count.
  - imem_ack outside FETCH, or with imem_req=0: ignored.
- pc4 is always pc+4, combinational; wraps at 32'hFFFF_FFFC -> 0.
- Decode fields are combinational slices of inst; they equal the NOP fields while inst_valid=0.
- Wrap-around:
  - pc+4 and pc+imm wrap silently (e.g. pc=32'hFFFF_FFFC, PC4 -> 0, no misalign).
  - retire_cnt wraps 32'hFFFF_FFFF -> 0.

Test Plan:
- Reset then ack held high → imem_req rises the first cycle after IDLE, addr=0. imem_rdata=32'h0050_0093 → next cycle inst_valid=1, opcode=7'b0010011, rd_addr=1. retire with NPC_PC4 → pc=4, retire_cnt=1.
- Ack delayed 3 cycles → imem_req and imem_addr stable for 4 cycles. A stray imem_ack during EXEC and a retire during FETCH cause no change.
- Branches at pc=32'h10, imm=32'hFFFF_FFF8:
  - NPC_BRA, br_taken=1 → pc=32'h08.
  - NPC_BRA, br_taken=0 → pc=32'h14.
- JAL and JALR at pc=32'h20:
  - NPC_JAL, imm=32'h100 → pc=32'h120, pc4 was 32'h24.
  - NPC_JALR, rs1_val=32'h1001, imm=0 → pc=32'h1000.
- Misalign: NPC_JALR with rs1_val=32'h102, imm=0 → misalign=1, misalign_addr=32'h102, imem_req stays 0 for 10 cycles. rst → misalign=0, pc=RESET_PC.
- Edge cases:
  - rst asserted mid-FETCH with ack in the same cycle → inst stays NOP_INST, inst_valid=0.
  - pc=32'hFFFF_FFFC with PC4 → pc=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch stage issues requests.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory answers them.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, fetches over a req/ack bus,
// exposes decode fields and computes the next PC on retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    npc_op,
  input  logic          br_taken,
  input  logic [31:0]   imm,
  input  logic [31:0]   rs1_val,
  input  logic          retire,
  fetch_unit_if.master  imem,
  output logic [31:0]   pc,
  output logic [31:0]   pc4,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic [6:0]    opcode,
  output logic [2:0]    funct3,
  output logic [6:0]    funct7,
  output logic [4:0]    rs1_addr,
  output logic [4:0]    rs2_addr,
  output logic [4:0]    rd_addr,
  output logic          misalign,
  output logic [31:0]   misalign_addr,
  output logic [31:0]   retire_cnt
);

  localparam logic [1:0] NpcPc4  = 2'b00;
  localparam logic [1:0] NpcBra  = 2'b01;
  localparam logic [1:0] NpcJal  = 2'b10;
  localparam logic [1:0] NpcJalr = 2'b11;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StTrap} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        mis_q, mis_d;
  logic [31:0] mis_addr_q, mis_addr_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_tgt;
  logic [31:0] npc;

  // Candidate next-PC values and the decoder-selected target.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    pc_plus_imm = pc_q + imm;
    jalr_tgt    = (rs1_val + imm) & 32'hFFFF_FFFE;
    npc         = pc_plus4;
    unique case (npc_op)
      NpcPc4:  npc = pc_plus4;
      NpcBra:  npc = br_taken ? pc_plus_imm : pc_plus4;
      NpcJal:  npc = pc_plus_imm;
      NpcJalr: npc = jalr_tgt;
    endcase
  end

  // Next-state logic: fetch handshake, retire handling and misalign trap.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    mis_d      = mis_q;
    mis_addr_d = mis_addr_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem.imem_ack) begin
          inst_d  = imem.imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (retire) begin
          cnt_d  = cnt_q + 32'd1;
          // Drop back to NOP so decode fields read as a bubble.
          inst_d = NOP_INST;
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            state_d = StFetch;
          end else begin
            // PC stays on the faulting instruction; only reset leaves the trap.
            mis_d      = 1'b1;
            mis_addr_d = npc;
            state_d    = StTrap;
          end
        end
      end
      StTrap: state_d = StTrap;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      mis_q      <= 1'b0;
      mis_addr_q <= 32'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs are decoded from state and sliced from the held instruction.
  always_comb begin
    imem.imem_req  = (state_q == StFetch);
    imem.imem_addr = pc_q;
    pc             = pc_q;
    pc4            = pc_plus4;
    inst           = inst_q;
    inst_valid     = (state_q == StExec);
    opcode         = inst_q[6:0];
    rd_addr        = inst_q[11:7];
    funct3         = inst_q[14:12];
    rs1_addr       = inst_q[19:15];
    rs2_addr       = inst_q[24:20];
    funct7         = inst_q[31:25];
    misalign       = mis_q;
    misalign_addr  = mis_addr_q;
    retire_cnt     = cnt_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected fetch
// addresses is filled at each retire and drained when a request appears.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] NopInst = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        retire;
  logic [31:0] pc, pc4, inst, misalign_addr, retire_cnt;
  logic        inst_valid, misalign;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (ResetPc),
    .NOP_INST (NopInst)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .npc_op        (npc_op),
    .br_taken      (br_taken),
    .imm           (imm),
    .rs1_val       (rs1_val),
    .retire        (retire),
    .imem          (bus.master),
    .pc            (pc),
    .pc4           (pc4),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rd_addr       (rd_addr),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .retire_cnt    (retire_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_cnt;
  logic [31:0] nop_w = NopInst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    retire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc, ResetPc);
    check("rst_inst", inst, NopInst);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_mis_addr", misalign_addr, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    model_pc  = ResetPc;
    model_cnt = 32'd0;
    exp_addr_q.delete();
    exp_addr_q.push_back(ResetPc);
    rst = 1'b0;
  endtask

  // Wait for a request, check address, hold it for delay cycles, then ack.
  task automatic do_fetch(input logic [31:0] rdata, input int delay, input bit stray_retire);
    int          n;
    logic [31:0] exp;
    logic [31:0] cnt0;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_addr_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    exp = exp_addr_q.pop_front();
    check("fetch_addr", bus.imem_addr, exp);
    check("fetch_bubble", {31'd0, inst_valid}, 32'd0);
    cnt0 = retire_cnt;
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack = 1'b0;
      retire = stray_retire && (i == 1);
      npc_op = 2'b10;
      imm = 32'h40;
      @(negedge clk);
      retire = 1'b0;
      check("wait_req", {31'd0, bus.imem_req}, 32'd1);
      check("wait_addr", bus.imem_addr, exp);
      if (stray_retire) check("stray_ret_cnt", retire_cnt, cnt0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("valid", {31'd0, inst_valid}, 32'd1);
    check("req_drop", {31'd0, bus.imem_req}, 32'd0);
    check("inst", inst, rdata);
    check("opcode", {25'd0, opcode}, {25'd0, rdata[6:0]});
    check("rd", {27'd0, rd_addr}, {27'd0, rdata[11:7]});
    check("f3", {29'd0, funct3}, {29'd0, rdata[14:12]});
    check("rs1", {27'd0, rs1_addr}, {27'd0, rdata[19:15]});
    check("rs2", {27'd0, rs2_addr}, {27'd0, rdata[24:20]});
    check("f7", {25'd0, funct7}, {25'd0, rdata[31:25]});
  endtask

  // Retire the held instruction; the model computes the expected target.
  task automatic do_retire(input logic [1:0] op, input logic br, input logic [31:0] im,
                           input logic [31:0] r1);
    logic [31:0] nxt;
    logic [31:0] p4;
    logic [31:0] old_pc;
    p4 = model_pc + 32'd4;
    check("pre_pc", pc, model_pc);
    check("pc4", pc4, p4);
    case (op)
      2'b00:   nxt = p4;
      2'b01:   nxt = br ? model_pc + im : p4;
      2'b10:   nxt = model_pc + im;
      default: nxt = (r1 + im) & 32'hFFFF_FFFE;
    endcase
    old_pc = model_pc;
    model_cnt = model_cnt + 32'd1;
    if (nxt[1:0] == 2'b00) begin
      model_pc = nxt;
      exp_addr_q.push_back(nxt);
    end
    npc_op = op;
    br_taken = br;
    imm = im;
    rs1_val = r1;
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    check("ret_cnt", retire_cnt, model_cnt);
    check("ret_valid", {31'd0, inst_valid}, 32'd0);
    check("ret_nop_op", {25'd0, opcode}, {25'd0, nop_w[6:0]});
    if (nxt[1:0] == 2'b00) begin
      check("ret_pc", pc, nxt);
      check("ret_mis", {31'd0, misalign}, 32'd0);
    end else begin
      check("trap_pc", pc, old_pc);
      check("trap_mis", {31'd0, misalign}, 32'd1);
      check("trap_mis_addr", misalign_addr, nxt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    npc_op = 2'b00;
    br_taken = 1'b0;
    imm = 32'd0;
    rs1_val = 32'd0;
    retire = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'd0;
    do_reset();

    // addi x1,x0,5 with zero-latency ack, then sequential retire.
    do_fetch(32'h0050_0093, 0, 1'b0);
    do_retire(2'b00, 1'b0, 32'd0, 32'd0);

    // Slow memory with a retire pulse mid-fetch; stray ack while executing.
    do_fetch(32'h0020_8133, 3, 1'b1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("stray_ack_inst", inst, 32'h0020_8133);
    check("stray_ack_valid", {31'd0, inst_valid}, 32'd1);
    do_retire(2'b10, 1'b0, 32'h0000_000C, 32'd0);   // -> 0x10

    do_fetch(32'hFE00_0CE3, 1, 1'b0);
    do_retire(2'b01, 1'b1, 32'hFFFF_FFF8, 32'd0);   // taken -> 0x08
    do_fetch(32'h0000_0013, 0, 1'b0);
    do_retire(2'b10, 1'b0, 32'h0000_0008, 32'd0);   // -> 0x10
    do_fetch(32'hFE00_0CE3, 2, 1'b0);
    do_retire(2'b01, 1'b0, 32'hFFFF_FFF8, 32'd0);   // not taken -> 0x14
    do_fetch(32'h00C0_006F, 0, 1'b0);
    do_retire(2'b10, 1'b0, 32'h0000_000C, 32'd0);   // -> 0x20
    do_fetch(32'h1000_00EF, 0, 1'b0);
    do_retire(2'b10, 1'b0, 32'h0000_0100, 32'd0);   // JAL -> 0x120
    do_fetch(32'h0000_8067, 1, 1'b0);
    do_retire(2'b11, 1'b0, 32'd0, 32'h0000_1001);   // JALR -> 0x1000
    do_fetch(32'h0000_006F, 0, 1'b0);
    do_retire(2'b10, 1'b0, 32'hFFFF_EFFC, 32'd0);   // -> 0xFFFF_FFFC
    do_fetch(32'h0000_0013, 0, 1'b0);
    do_retire(2'b00, 1'b0, 32'd0, 32'd0);           // wraps to 0
    check("wrap_pc", pc, 32'd0);

    // Misaligned JALR traps; nothing moves afterwards.
    do_fetch(32'h0000_8067, 0, 1'b0);
    do_retire(2'b11, 1'b0, 32'd0, 32'h0000_0102);
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack = 1'b1;
      retire = 1'b1;
      @(negedge clk);
      check("trap_req", {31'd0, bus.imem_req}, 32'd0);
      check("trap_hold_mis", {31'd0, misalign}, 32'd1);
      check("trap_hold_pc", pc, model_pc);
    end
    retire = 1'b0;
    bus.imem_ack = 1'b0;
    check("trap_cnt_hold", retire_cnt, model_cnt);

    do_reset();

    // Reset in the same cycle as an ack mid-fetch must win.
    @(negedge clk);
    check("mid_req", {31'd0, bus.imem_req}, 32'd1);
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("midrst_inst", inst, NopInst);
    check("midrst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    exp_addr_q.delete();
    exp_addr_q.push_back(ResetPc);
    model_pc = ResetPc;
    model_cnt = 32'd0;
    do_fetch(32'h0050_0093, 0, 1'b0);
    do_retire(2'b00, 1'b0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
